// File: rtl/aes_cone_rr_scheduler.sv
// aes_cone_rr_scheduler
//   Time-shares one combinational AES logic cone among NUM_REQ requesters.
//   A round-robin arbiter picks one request while idle, the operand is registered
//   onto the cone inputs for CONE_LAT cycles, then the cone output is captured and
//   returned with the requester ID. Only one transaction is ever in flight.
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_data   packed operands, requester i at [i*IN_W +: IN_W]
//   req_ready  one-hot grant, combinational, only ever set while idle
//   cone_in    registered operand driven to the cone
//   cone_out   cone result
//   rsp_valid  response valid, held until rsp_ready
//   rsp_ready  response consumer ready
//   rsp_id     requester that owns the response
//   rsp_data   captured cone result
//   busy       transaction in flight (evaluating or responding)
module aes_cone_rr_scheduler #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned IN_W     = 10,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned CONE_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [IN_W-1:0]         cone_in,
   input  logic                    cone_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    rsp_data,
   output logic                    busy
);

   localparam int unsigned CNT_W = $clog2(CONE_LAT) + 1;

   typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IN_W-1:0]   cone_in_q, cone_in_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_data_q, rsp_data_d;

   logic [2*NUM_REQ-1:0] valid_rot;
   logic                 grant_found;
   logic [ID_W-1:0]      grant_idx;
   logic [ID_W-1:0]      grant_next;
   logic [IN_W-1:0]      grant_data;
   logic [ID_W:0]        grant_sum;
   logic                 eval_done;

   // Rotate the valid vector so bit k corresponds to requester rr_ptr+k; the first
   // set bit from the bottom is then the round-robin winner.
   assign valid_rot = {req_valid, req_valid} >> rr_ptr_q;

   always_comb begin
      grant_found = 1'b0;
      grant_sum   = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            grant_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         end
      end
      if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
         grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
      end
      grant_idx = grant_sum[ID_W-1:0];
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         if (grant_idx == ID_W'(k)) begin
            grant_data = req_data[k*IN_W +: IN_W];
         end
      end
   end

   assign grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
   assign eval_done  = (cnt_q == CNT_W'(CONE_LAT - 1));

   // State register (all sequential state)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         cone_in_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         cone_in_q   <= cone_in_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      cone_in_d   = cone_in_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         StIdle: begin
            // A found grant is always accepted: ready is raised for exactly that valid.
            if (grant_found) begin
               cone_in_d = grant_data;
               rsp_id_d  = grant_idx;
               rr_ptr_d  = grant_next;
               cnt_d     = '0;
               state_d   = StEval;
            end
         end
         StEval: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (eval_done) begin
               rsp_data_d  = cone_out;
               rsp_valid_d = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready = '0;
      // Held off during reset so nothing looks accepted on a cycle that is discarded.
      if (state_q == StIdle && grant_found && !rst) begin
         req_ready[grant_idx] = 1'b1;
      end
      busy      = (state_q != StIdle);
      cone_in   = cone_in_q;
      rsp_valid = rsp_valid_q;
      rsp_id    = rsp_id_q;
      rsp_data  = rsp_data_q;
   end

endmodule
